// File: rtl/mxint_cast_fifo_pkg.sv
// Shared helpers for the MXINT precision cast and its block FIFO: exponent bias,
// mantissa saturation limits and the wide working type used by the cast datapath.
package mxint_cast_fifo_pkg;

  localparam int WIDE_WIDTH = 32;

  // Wide signed working type; mantissas are sign-extended into it before shifting.
  typedef logic signed [WIDE_WIDTH-1:0] wide_t;

  typedef struct packed {
    logic ovf;
    logic unf;
  } exp_flags_t;

  function automatic int bias(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int man_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int man_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/mx_block_fifo.sv
// Circular-buffer block FIFO with first-word-fall-through head, registered
// full/valid flags and an occupancy counter running 0..DEPTH.
module mx_block_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_next;
  logic             full_q;
  logic             valid_q;
  logic             wr_en;
  logic             rd_en;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PW'(1);
  endfunction

  // A full FIFO refuses the write even if the head is popped in the same cycle.
  assign in_ready  = !full_q;
  assign out_valid = valid_q;
  assign wr_en     = in_valid && !full_q;
  assign rd_en     = valid_q && out_ready;
  assign out_data  = valid_q ? mem[rd_ptr] : '0;

  always_comb begin
    count_next = count;
    case ({wr_en, rd_en})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      full_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
      if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
      count   <= count_next;
      full_q  <= (count_next == CNT_FULL);
      valid_q <= (count_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/mxint_cast_fifo.sv
// MXINT block precision cast (one register stage) feeding a DEPTH-entry block FIFO.
// Define MXINT_CAST_FIFO_ROUND_EN for round-to-nearest-even narrowing; otherwise narrowing truncates.
module mxint_cast_fifo
  import mxint_cast_fifo_pkg::*;
#(
  parameter int IN_MAN_WIDTH  = 8,
  parameter int IN_EXP_WIDTH  = 8,
  parameter int OUT_MAN_WIDTH = 8,
  parameter int OUT_EXP_WIDTH = 8,
  parameter int BLOCK_SIZE    = 4,
  parameter int DEPTH         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [IN_MAN_WIDTH-1:0]  mdata_in [BLOCK_SIZE],
  input  logic [IN_EXP_WIDTH-1:0]  edata_in,
  input  logic                     data_in_valid,
  output logic                     data_in_ready,
  output logic [OUT_MAN_WIDTH-1:0] mdata_out [BLOCK_SIZE],
  output logic [OUT_EXP_WIDTH-1:0] edata_out,
  output logic                     data_out_valid,
  input  logic                     data_out_ready
);

  typedef logic [OUT_MAN_WIDTH-1:0] man_out_t;

  localparam int    BIAS_IN  = bias(IN_EXP_WIDTH);
  localparam int    BIAS_OUT = bias(OUT_EXP_WIDTH);
  localparam int    EXP_MAX  = (1 << OUT_EXP_WIDTH) - 1;
  localparam int    SH_L     = (OUT_MAN_WIDTH > IN_MAN_WIDTH) ? OUT_MAN_WIDTH - IN_MAN_WIDTH : 0;
  localparam int    SH_R     = (IN_MAN_WIDTH > OUT_MAN_WIDTH) ? IN_MAN_WIDTH - OUT_MAN_WIDTH : 0;
  localparam int    FW       = OUT_EXP_WIDTH + OUT_MAN_WIDTH * BLOCK_SIZE;
  localparam wide_t MAN_MAX  = wide_t'(man_max(OUT_MAN_WIDTH));
  localparam wide_t MAN_MIN  = wide_t'(man_min(OUT_MAN_WIDTH));
`ifdef MXINT_CAST_FIFO_ROUND_EN
  // With no right shift the half value stays 1 so an empty remainder never rounds.
  localparam wide_t RND_HALF = wide_t'(1) << ((SH_R > 0) ? SH_R - 1 : 0);
  localparam wide_t RND_MASK = (wide_t'(1) << SH_R) - wide_t'(1);
`endif

  wide_t                    exp_sum;
  exp_flags_t               flags;
  man_out_t                 m_cast [BLOCK_SIZE];
  logic [OUT_EXP_WIDTH-1:0] e_cast;

  logic                     alive;
  logic                     cast_valid;
  man_out_t                 cast_m [BLOCK_SIZE];
  logic [OUT_EXP_WIDTH-1:0] cast_e;
  logic                     accept;
  logic                     fifo_push;
  logic                     fifo_not_full;
  logic [FW-1:0]            fifo_din;
  logic [FW-1:0]            fifo_dout;

  always_comb begin
    wide_t m_wide;
    wide_t m_q;
`ifdef MXINT_CAST_FIFO_ROUND_EN
    wide_t m_rem;
`endif
    exp_sum   = wide_t'(edata_in) - wide_t'(BIAS_IN) + wide_t'(BIAS_OUT);
    flags.ovf = (exp_sum > EXP_MAX);
    flags.unf = (exp_sum < 0);
    if (flags.ovf)      e_cast = '1;
    else if (flags.unf) e_cast = '0;
    else                e_cast = exp_sum[OUT_EXP_WIDTH-1:0];

    for (int i = 0; i < BLOCK_SIZE; i++) begin
      m_wide = wide_t'(signed'(mdata_in[i]));
      if (SH_L > 0) m_q = m_wide <<< SH_L;
      else          m_q = m_wide >>> SH_R;
`ifdef MXINT_CAST_FIFO_ROUND_EN
      m_rem = m_wide & RND_MASK;
      if ((m_rem > RND_HALF) || ((m_rem == RND_HALF) && m_q[0])) m_q = m_q + wide_t'(1);
`endif
      if (m_q > MAN_MAX)      m_q = MAN_MAX;
      else if (m_q < MAN_MIN) m_q = MAN_MIN;
      // Exponent out of range overrides the shifted mantissa; zero stays zero on overflow.
      if (flags.ovf) begin
        if (m_wide == '0)     m_q = '0;
        else if (m_wide < 0)  m_q = MAN_MIN;
        else                  m_q = MAN_MAX;
      end else if (flags.unf) begin
        m_q = '0;
      end
      m_cast[i] = m_q[OUT_MAN_WIDTH-1:0];
    end
  end

  // alive keeps the input closed while reset is held and opens it after release.
  assign data_in_ready = alive && (!cast_valid || fifo_not_full);
  assign accept        = data_in_valid && data_in_ready;
  assign fifo_push     = cast_valid && fifo_not_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive      <= 1'b0;
      cast_valid <= 1'b0;
      cast_e     <= '0;
      for (int i = 0; i < BLOCK_SIZE; i++) cast_m[i] <= '0;
    end else begin
      alive <= 1'b1;
      if (accept) begin
        cast_valid <= 1'b1;
        cast_e     <= e_cast;
        for (int i = 0; i < BLOCK_SIZE; i++) cast_m[i] <= m_cast[i];
      end else if (fifo_push) begin
        cast_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    fifo_din = '0;
    for (int i = 0; i < BLOCK_SIZE; i++) fifo_din[i*OUT_MAN_WIDTH +: OUT_MAN_WIDTH] = cast_m[i];
    fifo_din[FW-1 -: OUT_EXP_WIDTH] = cast_e;
  end

  mx_block_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_data   (fifo_din),
    .in_valid  (cast_valid),
    .in_ready  (fifo_not_full),
    .out_data  (fifo_dout),
    .out_valid (data_out_valid),
    .out_ready (data_out_ready)
  );

  always_comb begin
    for (int i = 0; i < BLOCK_SIZE; i++) mdata_out[i] = fifo_dout[i*OUT_MAN_WIDTH +: OUT_MAN_WIDTH];
    edata_out = fifo_dout[FW-1 -: OUT_EXP_WIDTH];
  end

endmodule

// File: tb/tb_mxint_cast_fifo.sv
// Bench for mxint_cast_fifo: a narrowing instance (8/8 -> 4/5, DEPTH 4) and an
// equal-precision instance (8/8 -> 8/8, DEPTH 8), each checked through a scoreboard queue.
module tb_mxint_cast_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] mi_n [4];
  logic [7:0] ei_n;
  logic       vi_n, ri_n;
  logic [3:0] mo_n [4];
  logic [4:0] eo_n;
  logic       vo_n, ro_n;

  logic [7:0] mi_p [4];
  logic [7:0] ei_p;
  logic       vi_p, ri_p;
  logic [7:0] mo_p [4];
  logic [7:0] eo_p;
  logic       vo_p, ro_p;

  mxint_cast_fifo #(
    .IN_MAN_WIDTH(8), .IN_EXP_WIDTH(8), .OUT_MAN_WIDTH(4), .OUT_EXP_WIDTH(5),
    .BLOCK_SIZE(4), .DEPTH(4)
  ) u_dut_n (
    .clk(clk), .rst(rst),
    .mdata_in(mi_n), .edata_in(ei_n), .data_in_valid(vi_n), .data_in_ready(ri_n),
    .mdata_out(mo_n), .edata_out(eo_n), .data_out_valid(vo_n), .data_out_ready(ro_n)
  );

  mxint_cast_fifo #(
    .IN_MAN_WIDTH(8), .IN_EXP_WIDTH(8), .OUT_MAN_WIDTH(8), .OUT_EXP_WIDTH(8),
    .BLOCK_SIZE(4), .DEPTH(8)
  ) u_dut_p (
    .clk(clk), .rst(rst),
    .mdata_in(mi_p), .edata_in(ei_p), .data_in_valid(vi_p), .data_in_ready(ri_p),
    .mdata_out(mo_p), .edata_out(eo_p), .data_out_valid(vo_p), .data_out_ready(ro_p)
  );

  int n_vec = 0;
  int n_mis = 0;
  int pops_n = 0;
  int max_occ = 0;
  logic [20:0] q_n [$];
  logic [39:0] q_p [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference cast for 8/8 -> 4/5: floor division by 16, optional ties-to-even rounding.
  function automatic logic [20:0] model_n(input int a, input int b, input int c, input int d, input int e);
    int ms [4];
    int eo, v, q, r;
    logic [20:0] res;
    ms = '{a, b, c, d};
    eo = e - 127 + 15;
    res = '0;
    for (int i = 0; i < 4; i++) begin
      v = ms[i];
      if (eo > 31) q = (v == 0) ? 0 : ((v < 0) ? -8 : 7);
      else if (eo < 0) q = 0;
      else begin
        q = (v >= 0) ? v / 16 : -((-v + 15) / 16);
`ifdef MXINT_CAST_FIFO_ROUND_EN
        r = v - q * 16;
        if (r > 8 || (r == 8 && (q % 2) != 0)) q = q + 1;
        if (q > 7) q = 7;
`endif
      end
      res[i*4 +: 4] = q[3:0];
    end
    if (eo > 31)     res[20:16] = 5'd31;
    else if (eo < 0) res[20:16] = 5'd0;
    else             res[20:16] = eo[4:0];
    return res;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (q_n.size() > max_occ) max_occ = q_n.size();
      if (vo_n && ro_n) begin
        pops_n++;
        chk("n_pop_expected", 64'(q_n.size() != 0), 64'd1);
        if (q_n.size() != 0)
          chk("n_block", 64'({eo_n, mo_n[3], mo_n[2], mo_n[1], mo_n[0]}), 64'(q_n.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && vo_p && ro_p) begin
      chk("p_pop_expected", 64'(q_p.size() != 0), 64'd1);
      if (q_p.size() != 0)
        chk("p_block", 64'({eo_p, mo_p[3], mo_p[2], mo_p[1], mo_p[0]}), 64'(q_p.pop_front()));
    end
  end

  task automatic send_n(input int a, input int b, input int c, input int d, input int e);
    bit ok = 1'b0;
    bit rdy;
    mi_n[0] = 8'(a); mi_n[1] = 8'(b); mi_n[2] = 8'(c); mi_n[3] = 8'(d);
    ei_n = 8'(e);
    vi_n = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk); rdy = ri_n;
      @(posedge clk);
      if (rdy) begin ok = 1'b1; q_n.push_back(model_n(a, b, c, d, e)); end
    end
    #1 vi_n = 1'b0;
    chk("n_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_p(input int a, input int b, input int c, input int d, input int e);
    bit ok = 1'b0;
    bit rdy;
    mi_p[0] = 8'(a); mi_p[1] = 8'(b); mi_p[2] = 8'(c); mi_p[3] = 8'(d);
    ei_p = 8'(e);
    vi_p = 1'b1;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk); rdy = ri_p;
      @(posedge clk);
      if (rdy) begin ok = 1'b1; q_p.push_back({8'(e), 8'(d), 8'(c), 8'(b), 8'(a)}); end
    end
    #1 vi_p = 1'b0;
    chk("p_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_rand_n();
    send_n($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
           $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
           $urandom_range(110, 150));
  endtask

  task automatic drain_n();
    for (int t = 0; t < 200 && q_n.size() != 0; t++) @(posedge clk);
    #1 chk("n_drained", 64'(q_n.size()), 64'd0);
  endtask

  task automatic drain_p();
    for (int t = 0; t < 200 && q_p.size() != 0; t++) @(posedge clk);
    #1 chk("p_drained", 64'(q_p.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, pops0, a, b, c, d, e;
    bit rdy, done;
    rst = 1'b1;
    vi_n = 1'b0; vi_p = 1'b0; ro_n = 1'b0; ro_p = 1'b0;
    ei_n = '0; ei_p = '0;
    for (int i = 0; i < 4; i++) begin mi_n[i] = '0; mi_p[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vo_n", 64'(vo_n), 64'd0);
    chk("rst_ri_n", 64'(ri_n), 64'd0);
    chk("rst_eo_n", 64'(eo_n), 64'd0);
    chk("rst_mo_n", 64'({mo_n[3], mo_n[2], mo_n[1], mo_n[0]}), 64'd0);
    chk("rst_vo_p", 64'(vo_p), 64'd0);
    chk("rst_ri_p", 64'(ri_p), 64'd0);
    chk("rst_eo_p", 64'(eo_p), 64'd0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_ri_n", 64'(ri_n), 64'd1);
    chk("post_rst_ri_p", 64'(ri_p), 64'd1);

    // Equal precision: bit-exact, head valid in the cycle after the FIFO write edge.
    ro_p = 1'b1;
    mi_p[0] = 8'd1; mi_p[1] = 8'hFE; mi_p[2] = 8'd3; mi_p[3] = 8'hFC; ei_p = 8'd130;
    vi_p = 1'b1;
    @(negedge clk) rdy = ri_p;
    chk("p_lat_ready", 64'(rdy), 64'd1);
    @(posedge clk);
    q_p.push_back({8'd130, 8'hFC, 8'd3, 8'hFE, 8'd1});
    #1 vi_p = 1'b0;
    @(negedge clk) chk("p_lat_cast_only", 64'(vo_p), 64'd0);
    @(negedge clk) chk("p_lat_head", 64'(vo_p), 64'd1);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++)
      send_p($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
             $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128,
             $urandom_range(0, 255));
    drain_p();

    // Narrowing, rounding/truncation and exponent limits.
    ro_n = 1'b1;
    @(posedge clk); #1;
    send_n(24, -24, 40, 127, 130);
    send_n(64, -64, 0, 5, 200);
    send_n(64, -64, 0, 5, 100);
    send_n(-128, 127, -1, 8, 142);
    send_n(-128, 127, -1, 8, 143);
    send_n(-128, 127, 1, 8, 111);
    send_n(-128, 127, 1, 8, 112);
    for (int k = 0; k < 6; k++) send_rand_n();
    drain_n();

    // Backpressure: 4 in the FIFO plus 1 in the cast register, then the 6th waits.
    ro_n = 1'b0;
    @(posedge clk); #1;
    pops0 = pops_n;
    acc = 0;
    a = 16; b = -16; c = 8; d = -8; e = 127;
    mi_n[0] = 8'(a); mi_n[1] = 8'(b); mi_n[2] = 8'(c); mi_n[3] = 8'(d); ei_n = 8'(e);
    vi_n = 1'b1;
    for (int t = 0; t < 30 && acc < 6; t++) begin
      if (t == 12) begin
        chk("n_bp_accepts", 64'(acc), 64'd5);
        chk("n_bp_ready_low", 64'(ri_n), 64'd0);
        ro_n = 1'b1;
      end
      @(negedge clk); rdy = ri_n;
      @(posedge clk);
      if (rdy) begin
        acc++;
        q_n.push_back(model_n(a, b, c, d, e));
        a = a + 17; b = b - 9; c = c + 33; d = d - 21; e = e + 1;
        #1;
        mi_n[0] = 8'(a); mi_n[1] = 8'(b); mi_n[2] = 8'(c); mi_n[3] = 8'(d); ei_n = 8'(e);
      end else #1;
    end
    vi_n = 1'b0;
    chk("n_bp_total", 64'(acc), 64'd6);
    drain_n();
    chk("n_bp_pops", 64'(pops_n - pops0), 64'd6);

    // Wrap-around with the consumer toggling every cycle.
    max_occ = 0;
    done = 1'b0;
    pops0 = pops_n;
    fork
      begin
        for (int k = 0; k < 20; k++) send_rand_n();
        drain_n();
        done = 1'b1;
      end
      begin
        for (int t = 0; t < 2000 && !done; t++) begin
          @(posedge clk); #1 ro_n = ~ro_n;
        end
      end
    join
    ro_n = 1'b1;
    chk("n_wrap_pops", 64'(pops_n - pops0), 64'd20);
    chk("n_wrap_occ_le_5", 64'(max_occ <= 5), 64'd1);

    // Asynchronous reset between edges with 3 blocks queued.
    ro_n = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) send_rand_n();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("n_queued_valid", 64'(vo_n), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_vo_n", 64'(vo_n), 64'd0);
    chk("arst_ri_n", 64'(ri_n), 64'd0);
    chk("arst_eo_n", 64'(eo_n), 64'd0);
    q_n.delete();
    #1 rst = 1'b0;
    pops0 = pops_n;
    @(posedge clk); #1;
    ro_n = 1'b1;
    send_n(7, -7, 33, -100, 135);
    drain_n();
    repeat (3) @(posedge clk);
    #1 chk("arst_fresh_pops", 64'(pops_n - pops0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
